// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED mode sequencer: mode encoding and datapath widths.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    localparam int unsigned STEP_W = 16;
    localparam int unsigned PWM_W  = 8;

    // Mode rotation taken on each accepted key press.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_COUNT:   return MODE_SCAN;
            MODE_SCAN:    return MODE_BREATHE;
            MODE_BREATHE: return MODE_OFF;
            default:      return MODE_COUNT;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser, stability debouncer and press-edge pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE = 1024,
    parameter int unsigned INV_BTN  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_db,
    output logic press
);

    localparam logic                INV      = (INV_BTN != 0);
    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             key_s;
    logic [CNT_W-1:0] stab_cnt;

    // Synchronise the raw pin; reset holds the released pin level so key_s reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= INV;
            sync_q2 <= INV;
        end else begin
            sync_q1 <= key_i;
            sync_q2 <= sync_q1;
        end
    end

    assign key_s = sync_q2 ^ INV;

    // Accept a new level after DEBOUNCE consecutive disagreeing cycles; pulse press on 0->1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
            key_db   <= 1'b0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s != key_db) begin
                if (stab_cnt == CNT_LAST) begin
                    key_db   <= key_s;
                    stab_cnt <= '0;
                    press    <= key_s;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED pattern sequencer: a debounced key cycles COUNT/SCAN/BREATHE/OFF, patterns step on a prescaled tick.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned LEDS_NR  = 6,
    parameter int unsigned TICK_DIV = 65536,
    parameter int unsigned DEBOUNCE = 1024,
    parameter int unsigned INV_BTN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_i,
    output logic [LEDS_NR-1:0] led
);

    localparam int unsigned      PCNT_W    = $clog2(TICK_DIV);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam int unsigned      POS_W     = $clog2(LEDS_NR);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LEDS_NR - 1);
    localparam logic [PWM_W-1:0] DUTY_MAX  = '1;

    logic               press;
    logic [PCNT_W-1:0]  pcnt;
    logic               tick;
    mode_t              mode;
    mode_t              mode_nxt;
    logic [STEP_W-1:0]  step;
    logic [POS_W-1:0]   pos;
    logic               dir_up;
    logic [PWM_W-1:0]   duty;
    logic               ramp_up;
    logic [PWM_W-1:0]   pwm;
    logic [LEDS_NR-1:0] led_nxt;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .INV_BTN  (INV_BTN)
    ) u_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_i  (key_i),
        .key_db (),
        .press  (press)
    );

    assign tick = (pcnt == PCNT_LAST);

    // Free-running prescaler, wraps after TICK_DIV cycles regardless of mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_COUNT;
        end else begin
            mode <= mode_nxt;
        end
    end

    // Next mode: advance one step per press.
    always_comb begin
        mode_nxt = mode;
        if (press) begin
            mode_nxt = next_mode(mode);
        end
    end

    // Pattern state: cleared on press (which masks a coincident tick), else stepped by tick in the active mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= '0;
            pos     <= '0;
            dir_up  <= 1'b1;
            duty    <= '0;
            ramp_up <= 1'b1;
            pwm     <= '0;
        end else begin
            pwm <= pwm + 1'b1;
            if (press) begin
                step    <= '0;
                pos     <= '0;
                dir_up  <= 1'b1;
                duty    <= '0;
                ramp_up <= 1'b1;
            end else if (tick) begin
                case (mode)
                    MODE_COUNT: begin
                        step <= step + 1'b1;
                    end
                    MODE_SCAN: begin
                        if (dir_up) begin
                            if (pos == POS_LAST) begin
                                dir_up <= 1'b0;
                                pos    <= pos - 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                dir_up <= 1'b1;
                                pos    <= pos + 1'b1;
                            end else begin
                                pos <= pos - 1'b1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        if (ramp_up) begin
                            if (duty == DUTY_MAX) begin
                                ramp_up <= 1'b0;
                                duty    <= duty - 1'b1;
                            end else begin
                                duty <= duty + 1'b1;
                            end
                        end else begin
                            if (duty == '0) begin
                                ramp_up <= 1'b1;
                                duty    <= duty + 1'b1;
                            end else begin
                                duty <= duty - 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output decode: LED image for the current mode and pattern state.
    always_comb begin
        led_nxt = '0;
        case (mode)
            MODE_COUNT:   led_nxt = step[LEDS_NR-1:0];
            MODE_SCAN:    led_nxt[pos] = 1'b1;
            MODE_BREATHE: led_nxt = {LEDS_NR{pwm < duty}};
            default:      led_nxt = '0;
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer (LEDS_NR=4, TICK_DIV=4, DEBOUNCE=8, INV_BTN=1).
module tb_led_mode_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned TD  = 4;
    localparam int unsigned DEB = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_i;
    logic [N-1:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    led_mode_sequencer #(
        .LEDS_NR  (N),
        .TICK_DIV (TD),
        .DEBOUNCE (DEB),
        .INV_BTN  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_i (key_i),
        .led   (led)
    );

    always #5 clk = ~clk;

    // Model state: cyc counts clocks since reset, k counts ticks since the last mode change.
    int unsigned  cyc  = 0;
    int unsigned  k    = 0;
    int unsigned  run  = 0;
    int unsigned  mode = 0;
    bit           s1   = 1'b1;
    bit           s2   = 1'b1;
    bit           db   = 1'b0;
    bit           prs  = 1'b0;
    bit           ks;
    logic [N-1:0] m_led = '0;

    // LED image as a closed-form function of mode, ticks elapsed in that mode and the pwm phase.
    function automatic logic [N-1:0] pattern(input int unsigned md, input int unsigned kk,
                                             input int unsigned pw);
        int unsigned p;
        int unsigned d;
        logic [N-1:0] r;
        r = '0;
        case (md)
            0: r = N'(kk % 65536);
            1: begin
                p = kk % (2 * (N - 1));
                if (p >= N) p = 2 * (N - 1) - p;
                r = N'(1 << p);
            end
            2: begin
                d = kk % 510;
                if (d > 255) d = 510 - d;
                r = (pw < d) ? '1 : '0;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = 0; k = 0; run = 0; mode = 0;
            s1 = 1'b1; s2 = 1'b1; db = 1'b0; prs = 1'b0; m_led = '0;
        end else begin
            m_led = pattern(mode, k, cyc % 256);
            if (prs) begin
                mode = (mode + 1) % 4;
                k    = 0;
            end else if ((cyc % TD) == TD - 1 && mode != 3) begin
                k = k + 1;
            end
            ks  = !s2;
            prs = 1'b0;
            if (ks != db) begin
                run = run + 1;
                if (run == DEB) begin
                    db  = ks;
                    run = 0;
                    prs = ks;
                end
            end else begin
                run = 0;
            end
            s2  = s1;
            s1  = key_i;
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: led=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("model", led, m_led);
    end

    // Hold the key 12 cycles, check the LED image right after the mode change lands, then release.
    task automatic press_key(input string name, input logic [N-1:0] exp);
        @(negedge clk) key_i = 1'b0;
        repeat (12) @(posedge clk);
        #1 check(name, led, exp);
        @(negedge clk) key_i = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    logic [N-1:0] scan_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [N-1:0] last;
    int           got;

    initial begin
        rst_n = 1'b0;
        key_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_led", led, 4'b0000);
        rst_n = 1'b1;

        // COUNT: 20 ticks then 17 more.
        repeat (82) @(posedge clk);
        #1 check("count_20", led, 4'b0100);
        repeat (68) @(posedge clk);
        #1 check("count_37", led, 4'b0101);

        // Short glitch must not register.
        @(negedge clk) key_i = 1'b0;
        repeat (5) @(negedge clk);
        key_i = 1'b1;
        repeat (20) @(negedge clk);

        // Real press -> SCAN, then collect the bounce sequence.
        @(negedge clk) key_i = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("scan_0", led, scan_exp[0]);
        last = led;
        got  = 1;
        @(negedge clk) key_i = 1'b1;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(posedge clk);
            #1;
            if (led !== last) begin
                check($sformatf("scan_%0d", got), led, scan_exp[got]);
                last = led;
                got++;
            end
        end
        if (got < 8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_timeout: saw %0d steps, required 8", got);
        end
        repeat (20) @(negedge clk);

        // BREATHE: starts dark, then run well past the peak and back up.
        press_key("breathe_entry", 4'b0000);
        repeat (2440) @(negedge clk);

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1 check("async_reset", led, 4'b0000);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("first_tick_wait", led, 4'b0000);
        @(posedge clk);
        #1 check("first_tick", led, 4'b0001);

        // Press lands on the tick that would take the count from 3 to 4.
        @(negedge clk) key_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("count_3", led, 4'b0011);
        repeat (2) @(posedge clk);
        #1 check("press_on_tick", led, 4'b0001);
        @(negedge clk) key_i = 1'b1;
        repeat (20) @(negedge clk);

        // Key held through reset release yields one press.
        @(negedge clk) begin
            key_i = 1'b0;
            rst_n = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 check("held_through_reset", led, 4'b0001);
        @(negedge clk) key_i = 1'b1;
        repeat (20) @(negedge clk);

        // Rotate through BREATHE and OFF back to COUNT.
        press_key("breathe_again", 4'b0000);
        press_key("off_entry", 4'b0000);
        repeat (40) @(negedge clk);
        check("off_hold", led, 4'b0000);
        press_key("count_again", 4'b0000);
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 SHALL have parameter LEDS_NR, default 6: number of LED outputs; legal range 2..16.
REQ-002 SHALL have parameter TICK_DIV, default 65536: clock cycles per pattern step tick; minimum 2.
REQ-003 SHALL have parameter DEBOUNCE, default 1024: stable cycles required to accept a key change; minimum 2.
REQ-004 SHALL have parameter INV_BTN, default 1: key_i polarity; 1 means the pin is low when pressed.
REQ-005 SHALL have port clk, input, 1 bit: single clock, driven by the on-chip oscillator output.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port key_i, input, 1 bit: raw asynchronous push-button.
REQ-008 SHALL have port led, output, LEDS_NR bits: registered LED drive; 1 = LED on.

Function
REQ-009 SHALL synchronise key_i through two flops, then XOR it with INV_BTN to form key_s (1 = pressed).
REQ-010 SHALL update debounced level key_db only after key_s differs from key_db for DEBOUNCE consecutive cycles; any agreeing cycle SHALL clear the stability counter.
REQ-011 SHALL generate press, a one-cycle pulse, on each key_db 0->1 transition; releases SHALL produce no event.
REQ-012 SHALL run prescaler pcnt 0..TICK_DIV-1; tick SHALL pulse for one cycle when pcnt==TICK_DIV-1, and pcnt SHALL then wrap to 0; the prescaler is free-running in all modes.
REQ-013 SHALL implement mode FSM COUNT->SCAN->BREATHE->OFF->COUNT, advancing one state per press.
REQ-014 On press, SHALL clear pattern state (step counter, scan position 0, direction up, duty 0, ramp up) in the same cycle; a tick coincident with press SHALL be ignored.
REQ-015 COUNT: 16-bit step counter SHALL increment per tick and wrap at 0xFFFF->0; led SHALL equal its low LEDS_NR bits.
REQ-016 SCAN: position SHALL move by 1 per tick; at LEDS_NR-1 moving up, and at 0 moving down, it SHALL reverse and step in the same tick (no dwell); led SHALL be one-hot at position.
REQ-017 BREATHE: 8-bit duty SHALL step +1 per tick up to 255, then -1 down to 0, then up again; an 8-bit pwm counter SHALL increment every clock; all led bits SHALL be (pwm < duty).
REQ-018 OFF: led SHALL be all zeros; the prescaler keeps running and no pattern state advances.
REQ-019 led SHALL be registered: it reflects mode/pattern state exactly one clock after that state updates.

Reset
REQ-020 While rst_n is low: led=0, mode=COUNT, all counters/duty/position=0, direction up, key_db=0, synchroniser flops at released level (key_s=0), press=0, tick=0.
REQ-021 Reset assertion mid-operation SHALL take effect immediately and asynchronously; after release, the first tick SHALL occur TICK_DIV cycles later.
REQ-022 A key held pressed through reset release SHALL produce one press after DEBOUNCE cycles.

Structure
REQ-023 Shared package led_seq_pkg SHALL hold the mode state encoding (2-bit: COUNT=0, SCAN=1, BREATHE=2, OFF=3), the step counter width (16) and the PWM width (8).
REQ-024 Synchroniser plus debouncer plus edge detection SHALL be sub-module key_debounce (ports clk, rst_n, key_i, key_db, press; parameters DEBOUNCE, INV_BTN).

Verification (LEDS_NR=4, TICK_DIV=4, DEBOUNCE=8, INV_BTN=1)
REQ-025 key_i low for 5 cycles, then high -> no press, mode stays COUNT; key_i low for 12 cycles -> exactly one press, mode=SCAN.
REQ-026 COUNT after reset, 20 ticks -> led=4'b0100; 17 further ticks -> led=4'b0101 (4-bit wrap 15->0 observed).
REQ-027 SCAN, 8 ticks -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-028 BREATHE -> duty 0 gives led=0 for 256 cycles; at duty 255, led=1111 for 255 of 256 cycles; the next tick gives duty 254.
REQ-029 press on the same cycle as tick in COUNT (counter=3) -> mode=SCAN, led=0001 next cycle, no count increment.
REQ-030 rst_n pulsed low in BREATHE at duty 100 -> led=0 asynchronously, mode=COUNT, first tick exactly 4 cycles after release.
